// File: rtl/vend_pkg.sv
// Shared types and constants for the vending-machine coin-return path.
package vend_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SELECT = 3'd1,
      EJECT  = 3'd2,
      DONE   = 3'd3,
      FAULT  = 3'd4
   } disp_state_t;

   typedef enum logic {
      COIN_NICKEL = 1'b0,
      COIN_DIME   = 1'b1
   } coin_t;

   localparam int NICKEL_UNITS = 1;
   localparam int DIME_UNITS   = 2;

endpackage

// File: rtl/vend_eject_timer.sv
// Loadable down-counter guarding the hopper handshake; expired flags the last allowed cycle.
module vend_eject_timer #(
   parameter int W = 4
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         i_clr,
   input  logic         i_start,
   input  logic         i_en,
   input  logic [W-1:0] i_load_val,
   output logic         o_expired
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge Clk) begin
      if (Reset || i_clr)
         r_cnt <= '0;
      else if (i_start)
         r_cnt <= i_load_val;
      else if (i_en && r_cnt != '0)
         r_cnt <= r_cnt - W'(1);
   end

   // Count of 1 while enabled means this is the final permitted cycle.
   assign o_expired = i_en && (r_cnt == W'(1));

endmodule

// File: rtl/vend_change_dispenser.sv
// Change dispenser: greedy dime-then-nickel payout with per-coin hopper handshake.
// Optional coin/short statistics ports are built when VEND_DISP_STATS_EN is defined.
module vend_change_dispenser
   import vend_pkg::*;
#(
   parameter int AMT_W         = 6,
   parameter int INV_W         = 8,
   parameter int EJECT_TIMEOUT = 15
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             req_valid,
   input  logic [AMT_W-1:0] req_amount,
   output logic             req_ready,
   input  logic             refill_valid,
   input  logic [INV_W-1:0] refill_dimes,
   input  logic [INV_W-1:0] refill_nickels,
   output logic             eject_dime,
   output logic             eject_nickel,
   input  logic             hopper_done,
   output logic             busy,
   output logic             done,
   output logic             short,
   output logic [AMT_W-1:0] residual,
   output logic [INV_W-1:0] dime_inv,
   output logic [INV_W-1:0] nickel_inv,
   output logic             fault
`ifdef VEND_DISP_STATS_EN
   ,
   output logic [15:0]      total_coins,
   output logic [7:0]       shorts
`endif
);

   localparam int TW = $clog2(EJECT_TIMEOUT + 1);

   function automatic logic [INV_W-1:0] sat_add(input logic [INV_W-1:0] a,
                                                input logic [INV_W-1:0] b);
      logic [INV_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[INV_W] ? {INV_W{1'b1}} : s[INV_W-1:0];
   endfunction

   disp_state_t      r_state, w_next;
   coin_t            r_coin, w_coin;
   logic [AMT_W-1:0] r_remaining, w_remaining;
   logic [INV_W-1:0] r_dime_inv, w_dime_inv;
   logic [INV_W-1:0] r_nickel_inv, w_nickel_inv;
   logic             r_short, w_short;
   logic [AMT_W-1:0] r_residual, w_residual;
   logic             r_eject_dime, r_eject_nickel, r_busy, r_done, r_fault, r_req_ready;
   logic             w_tmr_start, w_tmr_en, w_tmr_clr, w_expired, w_coin_out;

   vend_eject_timer #(.W(TW)) u_timer (
      .Clk        (Clk),
      .Reset      (Reset),
      .i_clr      (w_tmr_clr),
      .i_start    (w_tmr_start),
      .i_en       (w_tmr_en),
      .i_load_val (TW'(EJECT_TIMEOUT)),
      .o_expired  (w_expired)
   );

   always_comb begin
      w_next       = r_state;
      w_coin       = r_coin;
      w_remaining  = r_remaining;
      w_dime_inv   = r_dime_inv;
      w_nickel_inv = r_nickel_inv;
      w_short      = r_short;
      w_residual   = r_residual;
      w_tmr_start  = 1'b0;
      w_tmr_en     = 1'b0;
      w_tmr_clr    = 1'b0;
      w_coin_out   = 1'b0;
      case (r_state)
         IDLE: begin
            if (refill_valid) begin
               w_dime_inv   = sat_add(r_dime_inv, refill_dimes);
               w_nickel_inv = sat_add(r_nickel_inv, refill_nickels);
            end
            // The ready flop keeps the first post-reset cycle from accepting.
            if (req_valid && r_req_ready) begin
               w_remaining = req_amount;
               w_short     = 1'b0;
               w_residual  = '0;
               w_next      = SELECT;
            end
         end
         SELECT: begin
            if (r_remaining == '0) begin
               w_short = 1'b0;
               w_next  = DONE;
            end else if (r_remaining >= AMT_W'(DIME_UNITS) && r_dime_inv != '0) begin
               w_coin      = COIN_DIME;
               w_tmr_start = 1'b1;
               w_next      = EJECT;
            end else if (r_nickel_inv != '0) begin
               w_coin      = COIN_NICKEL;
               w_tmr_start = 1'b1;
               w_next      = EJECT;
            end else begin
               w_short    = 1'b1;
               w_residual = r_remaining;
               w_next     = DONE;
            end
         end
         EJECT: begin
            w_tmr_en = 1'b1;
            if (hopper_done) begin
               w_tmr_clr  = 1'b1;
               w_coin_out = 1'b1;
               if (r_coin == COIN_DIME) begin
                  w_dime_inv  = r_dime_inv - INV_W'(1);
                  w_remaining = r_remaining - AMT_W'(DIME_UNITS);
               end else begin
                  w_nickel_inv = r_nickel_inv - INV_W'(1);
                  w_remaining  = r_remaining - AMT_W'(NICKEL_UNITS);
               end
               w_next = SELECT;
            end else if (w_expired) begin
               w_tmr_clr = 1'b1;
               w_next    = FAULT;
            end
         end
         DONE:    w_next = IDLE;
         FAULT:   w_next = FAULT;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state        <= IDLE;
         r_coin         <= COIN_NICKEL;
         r_remaining    <= '0;
         r_dime_inv     <= '0;
         r_nickel_inv   <= '0;
         r_short        <= 1'b0;
         r_residual     <= '0;
         r_eject_dime   <= 1'b0;
         r_eject_nickel <= 1'b0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
         r_fault        <= 1'b0;
         r_req_ready    <= 1'b0;
      end else begin
         r_state        <= w_next;
         r_coin         <= w_coin;
         r_remaining    <= w_remaining;
         r_dime_inv     <= w_dime_inv;
         r_nickel_inv   <= w_nickel_inv;
         r_short        <= w_short;
         r_residual     <= w_residual;
         r_eject_dime   <= (w_next == EJECT) && (w_coin == COIN_DIME);
         r_eject_nickel <= (w_next == EJECT) && (w_coin == COIN_NICKEL);
         r_busy         <= (w_next == SELECT) || (w_next == EJECT) || (w_next == DONE);
         r_done         <= (w_next == DONE);
         r_fault        <= (w_next == FAULT);
         r_req_ready    <= (w_next == IDLE);
      end
   end

`ifdef VEND_DISP_STATS_EN
   logic [15:0] r_total_coins;
   logic [7:0]  r_shorts;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_total_coins <= '0;
         r_shorts      <= '0;
      end else begin
         if (w_coin_out && r_total_coins != 16'hFFFF)
            r_total_coins <= r_total_coins + 16'd1;
         if (w_next == DONE && w_short && r_shorts != 8'hFF)
            r_shorts <= r_shorts + 8'd1;
      end
   end

   assign total_coins = r_total_coins;
   assign shorts      = r_shorts;
`endif

   assign req_ready    = r_req_ready;
   assign eject_dime   = r_eject_dime;
   assign eject_nickel = r_eject_nickel;
   assign busy         = r_busy;
   assign done         = r_done;
   assign short        = r_short;
   assign residual     = r_residual;
   assign dime_inv     = r_dime_inv;
   assign nickel_inv   = r_nickel_inv;
   assign fault        = r_fault;

endmodule

// File: doc/vend_change_dispenser.md
Name: vend_change_dispenser

Overview:
Coin-return side of the vending machine: the opposite direction to the nickel/dime coin-acceptor FSM. It accepts a change request in nickel units and drives the coin hopper to eject dimes and nickels, one coin at a time, with a per-coin handshake. It tracks on-board coin inventory and reports shortfall and hopper faults to the vend controller.

Parameters:
AMT_W, 6, width of the change amount in nickel units (max 63 = $3.15)
INV_W, 8, width of each coin inventory counter
EJECT_TIMEOUT, 15, maximum cycles eject is held waiting for hopper_done before fault

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-high reset
req_valid  in  1  change request strobe
req_amount  in  AMT_W  change owed, in nickels
req_ready  out  1  high only in IDLE and not faulted
refill_valid  in  1  inventory add strobe
refill_dimes  in  INV_W  dimes to add
refill_nickels  in  INV_W  nickels to add
eject_dime  out  1  hopper command: eject one dime, held until done
eject_nickel  out  1  hopper command: eject one nickel, held until done
hopper_done  in  1  hopper has ejected the commanded coin
busy  out  1  request in progress
done  out  1  one-cycle completion pulse
short  out  1  valid with done: change could not be fully paid
residual  out  AMT_W  valid with done: unpaid nickels
dime_inv  out  INV_W  current dime inventory
nickel_inv  out  INV_W  current nickel inventory
fault  out  1  sticky hopper timeout

Behaviour:
- Reset: state IDLE. All outputs 0; req_ready goes to 1 the first cycle after Reset deasserts. Inventories cleared to 0; timer cleared. Reset mid-eject drops eject_* on the next edge.
- States: IDLE, SELECT, EJECT, DONE, FAULT. All outputs registered.
- IDLE: on req_valid, latch remaining = req_amount; go to SELECT next cycle (busy=1).
- IDLE refill: on refill_valid, add refill_* to each inventory, saturating at 2^INV_W-1. Refill is ignored outside IDLE.
- IDLE with both req_valid and refill_valid: the refill is applied and the request is accepted. SELECT uses the updated inventory.
- SELECT (one cycle). Rules are evaluated in order; the first match wins:
  - remaining==0: go to DONE, short=0.
  - remaining>=2 and dime_inv>0: go to EJECT with eject_dime=1.
  - nickel_inv>0: go to EJECT with eject_nickel=1.
  - otherwise: go to DONE, short=1, residual=remaining.
- Greedy rule: dimes are used first. When remaining is odd or dimes run out, nickels cover the rest.
- EJECT:
  - Exactly one eject_* is high, held steady.
  - On the cycle hopper_done is sampled high: drop eject_*, decrement that inventory, subtract 2 (dime) or 1 (nickel) from remaining, go to SELECT.
  - hopper_done while neither eject is active is ignored.
  - The timer counts cycles in EJECT. If it reaches EJECT_TIMEOUT without hopper_done, go to FAULT.
- DONE: done=1 for exactly one cycle, with short/residual valid. Then return to IDLE. short/residual hold until the next accepted request.
- FAULT: fault=1, eject_* = 0, req_ready=0, busy=0. Inventories frozen. Only Reset exits.
- Latency:
  - amount 0: done 2 cycles after acceptance.
  - per coin: 1 SELECT cycle + handshake cycles, minimum 2 cycles per coin when hopper_done is returned 1 cycle after eject rises.
- req_valid while busy: ignored, no queuing.

Optional Feature:
- Macro VEND_DISP_STATS_EN.
- Defined: adds output port total_coins[15:0], a count of coins ejected since Reset that saturates at 0xFFFF, plus output shorts[7:0], a saturating count of done pulses with short=1.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package vend_pkg holds:
  - disp_state_t enum (IDLE, SELECT, EJECT, DONE, FAULT)
  - NICKEL_UNITS=1 and DIME_UNITS=2 constants
  - coin_t enum (COIN_NICKEL, COIN_DIME)
- Sub-module vend_eject_timer: a loadable down-counter with clear, a start input and an expired output. It is instantiated once for the EJECT timeout.

Test Plan:
- Refill 3 dimes + 3 nickels, then request 7 with hopper_done 1 cycle after each eject -> eject sequence D,D,D,N. Then done with short=0, residual=0, dime_inv=0, nickel_inv=2.
- Refill 0 dimes + 2 nickels, request 5 -> ejects N,N, then done with short=1, residual=3, nickel_inv=0.
- Request 0 -> no eject; done pulses 2 cycles after acceptance with short=0. Pulse req_valid again while busy during a 4-nickel request -> the second request is ignored.
- Request 2 with 1 dime and hopper_done never asserted -> eject_dime held 15 cycles, then fault=1 and eject_dime=0. req_ready stays 0 until Reset, after which all outputs are 0.
- Refill 250 dimes twice -> dime_inv saturates at 255. Refill and request 1 in the same IDLE cycle with empty inventory plus 1 nickel -> request is paid with that nickel, short=0.
- Assert Reset during EJECT -> eject_* low on the next edge, inventories 0, state IDLE. With VEND_DISP_STATS_EN, total_coins resets to 0.
